phs_flow_classifier: RTL and testbench

//  Downstream of the N3 parser: consumes the 15-byte PHS key (phs_i/phs_valid_i) and maps it to a flow ID.

---
 rtl/phs_flow_classifier_pkg.sv | 34 +++
 rtl/phs_flow_classifier_cmp.sv | 42 ++++
 rtl/phs_flow_classifier.sv | 254 +++++++++++++++++++++++++
 tb/tb_phs_flow_classifier.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/phs_flow_classifier_pkg.sv
// ---------------------------------------------------------------------------
// phs_flow_classifier_pkg
//   Shared types for the PHS flow classifier: FSM state encoding, the
//   response record returned to the QoS/forwarding stage, the PHS key width
//   and a 16-bit saturating increment used by the drop/hit counters.
// ---------------------------------------------------------------------------
package phs_flow_classifier_pkg;

  // 15-byte PHS key produced by the N3 parser.
  localparam int PHS_KEY_W = 120;

  // Container width for the flow ID inside the response record. The top
  // module narrows it to its own ID_W (which must not exceed this).
  localparam int PHS_FLOW_ID_W = 8;

  typedef enum logic [1:0] {
    PF_IDLE,
    PF_SEARCH,
    PF_LEARN,
    PF_RESP
  } PHS_FLOW_STATES;

  // 'new' is a reserved word, so the learned flag is carried as is_new.
  typedef struct packed {
    logic [PHS_FLOW_ID_W-1:0] id;
    logic                     is_new;
    logic                     miss;
  } phs_flow_rsp_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/phs_flow_classifier_cmp.sv
// ---------------------------------------------------------------------------
// phs_flow_cmp
//   Combinational lane comparator. Compares LANES table entries (key plus
//   valid bit) against the key under lookup and reports whether any lane
//   hit and which is the lowest hitting lane.
// Ports
//   lane_key_i  in   LANES x KEY_W  keys of the group being searched
//   lane_vld_i  in   LANES          valid bits of the same entries
//   key_i       in   KEY_W          key under lookup
//   hit_o       out  1              at least one valid lane matches
//   hit_lane_o  out  LANE_W         lowest matching lane (0 when no hit)
// ---------------------------------------------------------------------------
module phs_flow_cmp
  import phs_flow_classifier_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int KEY_W  = PHS_KEY_W,
  parameter int LANE_W = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic [LANES-1:0][KEY_W-1:0] lane_key_i,
  input  logic [LANES-1:0]            lane_vld_i,
  input  logic [KEY_W-1:0]            key_i,
  output logic                        hit_o,
  output logic [LANE_W-1:0]           hit_lane_o
);

  logic [LANES-1:0] match;

  always_comb begin
    match      = '0;
    hit_lane_o = '0;
    for (int l = 0; l < LANES; l++) begin
      match[l] = lane_vld_i[l] && (lane_key_i[l] == key_i);
    end
    // Scan downwards so the lowest matching lane is the last one written.
    for (int l = LANES - 1; l >= 0; l--) begin
      if (match[l]) hit_lane_o = LANE_W'(l);
    end
    hit_o = |match;
  end

endmodule

// File: rtl/phs_flow_classifier.sv
// ---------------------------------------------------------------------------
// phs_flow_classifier
//   Maps a 15-byte PHS key to a flow ID. Keys are looked up in a small
//   flop-based table, LANES entries per SEARCH cycle; a key that misses the
//   whole table is learned into the lowest free entry (or reported as a miss
//   when the table is full). The result is offered on a valid/ready
//   handshake. Keys arriving while a lookup is in flight (or during a
//   flush) are dropped and counted.
//
// Optional feature (macro PHS_FLOW_STATS_EN): per-entry 16-bit saturating
//   hit counters with a registered read port (stat_idx_i / stat_cnt_o).
//
// Ports
//   CLK           in   1      clock
//   reset         in   1      asynchronous active-high reset
//   phs_i         in   KEY_W  PHS key, sampled when phs_valid_i=1 in IDLE
//   phs_valid_i   in   1      single-cycle key strobe
//   flush_i       in   1      clears the table and aborts any lookup
//   flow_id_o     out  ID_W   matched/learned entry index, 0 on miss
//   flow_new_o    out  1      entry learned by this lookup
//   flow_miss_o   out  1      table full, key not learned
//   flow_valid_o  out  1      response valid, held until flow_ready_i
//   flow_ready_i  in   1      consumer accepts the response
//   drop_cnt_o    out  16     saturating count of dropped keys
//   table_full_o  out  1      all entries valid (registered)
//   stat_idx_i    in   ID_W   (PHS_FLOW_STATS_EN) counter read index
//   stat_cnt_o    out  16     (PHS_FLOW_STATS_EN) counter value, 1-cycle read
// ---------------------------------------------------------------------------
module phs_flow_classifier
  import phs_flow_classifier_pkg::*;
#(
  parameter int NUM_FLOWS = 16,
  parameter int LANES     = 4,
  parameter int KEY_W     = PHS_KEY_W,
  parameter int ID_W      = $clog2(NUM_FLOWS)
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [KEY_W-1:0] phs_i,
  input  logic             phs_valid_i,
  input  logic             flush_i,
  output logic [ID_W-1:0]  flow_id_o,
  output logic             flow_new_o,
  output logic             flow_miss_o,
  output logic             flow_valid_o,
  input  logic             flow_ready_i,
  output logic [15:0]      drop_cnt_o,
  output logic             table_full_o
`ifdef PHS_FLOW_STATS_EN
  ,
  input  logic [ID_W-1:0]  stat_idx_i,
  output logic [15:0]      stat_cnt_o
`endif
);

  localparam int GROUPS = NUM_FLOWS / LANES;
  localparam int GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(GROUPS - 1);

  // Control state (asynchronously reset)
  PHS_FLOW_STATES         state_q, state_d;
  logic [GRP_W-1:0]       grp_q, grp_d;
  logic [NUM_FLOWS-1:0]   vld_q, vld_d;
  phs_flow_rsp_t          rsp_q, rsp_d;
  logic                   rsp_vld_q, rsp_vld_d;
  logic [15:0]            drop_q, drop_d;
  logic                   full_q;

  // Datapath storage (no reset; qualified by the valid bits / FSM state)
  logic [KEY_W-1:0]       key_q;
  logic [KEY_W-1:0]       key_mem_q [NUM_FLOWS];

  logic                   accept;
  logic                   learn_wr;
  logic [LANES-1:0][KEY_W-1:0] lane_key;
  logic [LANES-1:0]       lane_vld;
  logic                   hit;
  logic [LANE_W-1:0]      hit_lane;
  logic [ID_W-1:0]        hit_idx;
  logic                   free_found;
  logic [ID_W-1:0]        free_idx;
  logic [PHS_FLOW_ID_W-1:0] unused_rsp_id;

  function automatic logic [ID_W-1:0] entry_idx(input logic [GRP_W-1:0] g,
                                                input int lane);
    return ID_W'(int'(g) * LANES + lane);
  endfunction

  // Gather the group currently being searched.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_key[l] = key_mem_q[entry_idx(grp_q, l)];
      lane_vld[l] = vld_q[entry_idx(grp_q, l)];
    end
  end

  phs_flow_cmp #(
    .LANES  (LANES),
    .KEY_W  (KEY_W),
    .LANE_W (LANE_W)
  ) u_cmp (
    .lane_key_i (lane_key),
    .lane_vld_i (lane_vld),
    .key_i      (key_q),
    .hit_o      (hit),
    .hit_lane_o (hit_lane)
  );

  assign hit_idx = entry_idx(grp_q, int'(hit_lane));

  // Lowest free entry: scan downwards so the lowest index is written last.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_FLOWS - 1; i >= 0; i--) begin
      if (!vld_q[i]) begin
        free_found = 1'b1;
        free_idx   = ID_W'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grp_d     = grp_q;
    vld_d     = vld_q;
    rsp_d     = rsp_q;
    rsp_vld_d = rsp_vld_q;
    drop_d    = drop_q;
    accept    = 1'b0;
    learn_wr  = 1'b0;

    // A strobe is only taken in IDLE with no flush; everything else drops.
    if (phs_valid_i && (flush_i || (state_q != PF_IDLE))) begin
      drop_d = sat_inc16(drop_q);
    end

    if (flush_i) begin
      state_d   = PF_IDLE;
      vld_d     = '0;
      rsp_d     = '0;
      rsp_vld_d = 1'b0;
    end else begin
      case (state_q)
        PF_IDLE: begin
          if (phs_valid_i) begin
            accept  = 1'b1;
            grp_d   = '0;
            state_d = PF_SEARCH;
          end
        end
        PF_SEARCH: begin
          if (hit) begin
            rsp_d.id     = PHS_FLOW_ID_W'(hit_idx);
            rsp_d.is_new = 1'b0;
            rsp_d.miss   = 1'b0;
            rsp_vld_d    = 1'b1;
            state_d      = PF_RESP;
          end else if (grp_q == GRP_LAST) begin
            state_d = PF_LEARN;
          end else begin
            grp_d = grp_q + GRP_W'(1);
          end
        end
        PF_LEARN: begin
          if (free_found) begin
            vld_d[free_idx] = 1'b1;
            learn_wr        = 1'b1;
            rsp_d.id        = PHS_FLOW_ID_W'(free_idx);
            rsp_d.is_new    = 1'b1;
            rsp_d.miss      = 1'b0;
          end else begin
            rsp_d.id     = '0;
            rsp_d.is_new = 1'b0;
            rsp_d.miss   = 1'b1;
          end
          rsp_vld_d = 1'b1;
          state_d   = PF_RESP;
        end
        PF_RESP: begin
          if (flow_ready_i) begin
            rsp_d     = '0;
            rsp_vld_d = 1'b0;
            state_d   = PF_IDLE;
          end
        end
        default: state_d = PF_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q   <= PF_IDLE;
      grp_q     <= '0;
      vld_q     <= '0;
      rsp_q     <= '0;
      rsp_vld_q <= 1'b0;
      drop_q    <= '0;
      full_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grp_q     <= grp_d;
      vld_q     <= vld_d;
      rsp_q     <= rsp_d;
      rsp_vld_q <= rsp_vld_d;
      drop_q    <= drop_d;
      // Built from the next valid bits so it rises the cycle after LEARN
      // and falls the cycle after a flush.
      full_q    <= &vld_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (accept)   key_q <= phs_i;
    if (learn_wr) key_mem_q[free_idx] <= key_q;
  end

`ifdef PHS_FLOW_STATS_EN
  logic        hit_upd;
  logic [15:0] hcnt_q [NUM_FLOWS];
  logic [15:0] stat_q;

  assign hit_upd = (state_q == PF_SEARCH) && hit && !flush_i;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_FLOWS; i++) hcnt_q[i] <= '0;
      stat_q <= '0;
    end else begin
      if (flush_i) begin
        for (int i = 0; i < NUM_FLOWS; i++) hcnt_q[i] <= '0;
      end else if (hit_upd) begin
        hcnt_q[hit_idx] <= sat_inc16(hcnt_q[hit_idx]);
      end else if (learn_wr) begin
        hcnt_q[free_idx] <= 16'd1;
      end
      stat_q <= hcnt_q[stat_idx_i];
    end
  end

  assign stat_cnt_o = stat_q;
`endif

  assign unused_rsp_id = rsp_q.id;
  assign flow_id_o     = rsp_q.id[ID_W-1:0];
  assign flow_new_o    = rsp_q.is_new;
  assign flow_miss_o   = rsp_q.miss;
  assign flow_valid_o  = rsp_vld_q;
  assign drop_cnt_o    = drop_q;
  assign table_full_o  = full_q;

endmodule

// File: tb/tb_phs_flow_classifier.sv
module tb_phs_flow_classifier;

  localparam int NF = 16;
  localparam int LN = 4;
  localparam int KW = 120;
  localparam int IW = 4;

  logic          CLK = 1'b0;
  logic          reset;
  logic [KW-1:0] phs_i;
  logic          phs_valid_i;
  logic          flush_i;
  logic [IW-1:0] flow_id_o;
  logic          flow_new_o;
  logic          flow_miss_o;
  logic          flow_valid_o;
  logic          flow_ready_i;
  logic [15:0]   drop_cnt_o;
  logic          table_full_o;
`ifdef PHS_FLOW_STATS_EN
  logic [IW-1:0] stat_idx_i;
  logic [15:0]   stat_cnt_o;
`endif

  phs_flow_classifier #(.NUM_FLOWS(NF), .LANES(LN), .KEY_W(KW)) dut (
    .CLK          (CLK),
    .reset        (reset),
    .phs_i        (phs_i),
    .phs_valid_i  (phs_valid_i),
    .flush_i      (flush_i),
    .flow_id_o    (flow_id_o),
    .flow_new_o   (flow_new_o),
    .flow_miss_o  (flow_miss_o),
    .flow_valid_o (flow_valid_o),
    .flow_ready_i (flow_ready_i),
    .drop_cnt_o   (drop_cnt_o),
    .table_full_o (table_full_o)
`ifdef PHS_FLOW_STATS_EN
    ,
    .stat_idx_i   (stat_idx_i),
    .stat_cnt_o   (stat_cnt_o)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [IW-1:0] id;
    logic          nw;
    logic          miss;
    int            lat;
  } exp_t;

  exp_t          sb[$];
  logic [KW-1:0] mkeys[$];
  int            checks = 0;
  int            failures = 0;
  logic [15:0]   exp_drop = 16'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [KW-1:0] mk_key(input int n);
    logic [KW-1:0] k;
    k = {8'hC3, 16'(n * 7919), 64'h0F1E_2D3C_4B5A_6978, 32'(n)};
    return k;
  endfunction

  // Reference table: index = flow ID, learned in arrival order.
  function automatic exp_t model(input logic [KW-1:0] k);
    exp_t e;
    bit   found;
    e.id = '0; e.nw = 1'b0; e.miss = 1'b0; e.lat = NF / LN + 1;
    found = 1'b0;
    for (int i = 0; i < mkeys.size(); i++) begin
      if (!found && mkeys[i] == k) begin
        found = 1'b1;
        e.id  = IW'(i);
        e.lat = i / LN + 1;
      end
    end
    if (!found) begin
      if (mkeys.size() < NF) begin
        e.id = IW'(mkeys.size());
        e.nw = 1'b1;
        mkeys.push_back(k);
      end else begin
        e.miss = 1'b1;
      end
    end
    return e;
  endfunction

  // All tasks start and end just after a falling edge.
  task automatic start_key(input logic [KW-1:0] k);
    sb.push_back(model(k));
    phs_i       = k;
    phs_valid_i = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    phs_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int   lat;
    exp_t e;
    lat = 0;
    while (lat < 32) begin
      @(posedge CLK);
      lat++;
      @(negedge CLK);
      if (flow_valid_o) break;
    end
    e = sb.pop_front();
    check({tag, "_valid"}, 32'(flow_valid_o), 32'd1);
    check({tag, "_lat"},   32'(lat),          32'(e.lat));
    check({tag, "_id"},    32'(flow_id_o),    32'(e.id));
    check({tag, "_new"},   32'(flow_new_o),   32'(e.nw));
    check({tag, "_miss"},  32'(flow_miss_o),  32'(e.miss));
  endtask

  task automatic finish_hs(input string tag, input bit strobe);
    if (strobe) begin
      phs_i       = mk_key(999);
      phs_valid_i = 1'b1;
      exp_drop    = exp_drop + 16'd1;
    end
    @(negedge CLK);
    phs_valid_i = 1'b0;
    check({tag, "_released"}, 32'(flow_valid_o), 32'd0);
  endtask

  task automatic lookup(input logic [KW-1:0] k, input string tag, input bit strobe);
    start_key(k);
    wait_rsp(tag);
    finish_hs(tag, strobe);
  endtask

  logic [KW-1:0] key_a, key_b, key_c, key_d;
  int            seen;

  initial begin
    key_a = 120'h0123_4567_89AB_CDEF_FEDC_BA98_7654_32;
    key_b = 120'h1111_2222_3333_4444_5555_6666_7777_88;
    key_c = 120'hDEAD_BEEF_CAFE_F00D_0BAD_F00D_1234_56;
    key_d = 120'h5A5A_A5A5_0000_FFFF_1357_9BDF_2468_AC;
    reset = 1'b1; phs_i = '0; phs_valid_i = 1'b0; flush_i = 1'b0; flow_ready_i = 1'b1;
`ifdef PHS_FLOW_STATS_EN
    stat_idx_i = '0;
`endif
    repeat (3) @(negedge CLK);
    check("rst_valid", 32'(flow_valid_o), 32'd0);
    check("rst_id",    32'(flow_id_o),    32'd0);
    check("rst_new",   32'(flow_new_o),   32'd0);
    check("rst_miss",  32'(flow_miss_o),  32'd0);
    check("rst_drop",  32'(drop_cnt_o),   32'd0);
    check("rst_full",  32'(table_full_o), 32'd0);
    reset = 1'b0;
    @(negedge CLK);

    // Learn A, then hit it.
    lookup(key_a, "t1_learnA", 1'b0);
    lookup(key_a, "t1_hitA", 1'b0);

    // Fill the table: A is entry 0, K1..K15 take entries 1..15.
    for (int n = 1; n < NF; n++) lookup(mk_key(n), "t2_fill", 1'b0);
    check("t2_full", 32'(table_full_o), 32'd1);
    lookup(mk_key(15), "t2_hitK15", 1'b0);
    lookup(mk_key(16), "t2_missK16", 1'b0);
    lookup(mk_key(16), "t2_missK16b", 1'b0);
    lookup(mk_key(9), "t2_hitK9", 1'b0);
    check("t2_full_kept", 32'(table_full_o), 32'd1);

    // Backpressure with strobes while the response is held.
    flow_ready_i = 1'b0;
    start_key(mk_key(3));
    wait_rsp("t3_hitK3");
    for (int c = 0; c < 10; c++) begin
      phs_i       = mk_key(100 + c);
      phs_valid_i = (c % 3 == 1);
      @(negedge CLK);
      check("t3_hold_valid", 32'(flow_valid_o), 32'd1);
      check("t3_hold_id",    32'(flow_id_o),    32'd3);
    end
    phs_valid_i = 1'b0;
    exp_drop = exp_drop + 16'd3;
    check("t3_drop", 32'(drop_cnt_o), 32'(exp_drop));
    flow_ready_i = 1'b1;
    finish_hs("t3", 1'b0);

    // Flush during SEARCH aborts the lookup and empties the table.
    phs_i = mk_key(16); phs_valid_i = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    phs_valid_i = 1'b0; flush_i = 1'b1;
    @(negedge CLK);
    flush_i = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge CLK);
      if (flow_valid_o) seen++;
    end
    mkeys.delete();
    check("t4_no_rsp", 32'(seen), 32'd0);
    check("t4_full", 32'(table_full_o), 32'd0);
    check("t4_drop", 32'(drop_cnt_o), 32'(exp_drop));
    lookup(key_a, "t4_relearnA", 1'b0);

    // Strobe in the handshake cycle is dropped; the next cycle is accepted.
    lookup(key_b, "t5_learnB", 1'b1);
    check("t5_drop", 32'(drop_cnt_o), 32'(exp_drop));
    lookup(key_c, "t5_learnC", 1'b0);
    lookup(key_b, "t5_hitB", 1'b0);

    // Async reset while D is being learned.
    start_key(key_d);
    repeat (4) @(negedge CLK);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_valid", 32'(flow_valid_o), 32'd0);
    check("t6_rst_new",   32'(flow_new_o),   32'd0);
    check("t6_rst_drop",  32'(drop_cnt_o),   32'd0);
    check("t6_rst_full",  32'(table_full_o), 32'd0);
    sb.delete(); mkeys.delete(); exp_drop = 16'd0;
    @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);
    lookup(key_a, "t6_learnA", 1'b0);
    lookup(key_d, "t6_learnD", 1'b0);

    // Drop-counter saturation while a response is held.
    flow_ready_i = 1'b0;
    start_key(key_d);
    wait_rsp("t6_hitD");
    phs_valid_i = 1'b1;
    repeat (65534) @(negedge CLK);
    check("t6_drop_fffe", 32'(drop_cnt_o), 32'h0000_FFFE);
    repeat (6) @(negedge CLK);
    phs_valid_i = 1'b0;
    check("t6_drop_sat", 32'(drop_cnt_o), 32'h0000_FFFF);
    check("t6_hold_id", 32'(flow_id_o), 32'd1);
    flow_ready_i = 1'b1;
    finish_hs("t6", 1'b0);

`ifdef PHS_FLOW_STATS_EN
    // A was learned (1) and D learned + hit once (2); hit A five more times.
    for (int n = 0; n < 5; n++) lookup(key_a, "t7_hitA", 1'b0);
    stat_idx_i = '0;
    @(negedge CLK);
    check("t7_stat_A", 32'(stat_cnt_o), 32'd6);
    stat_idx_i = IW'(1);
    @(negedge CLK);
    check("t7_stat_D", 32'(stat_cnt_o), 32'd2);
`endif

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
